// File: rtl/xdma_dsc_pkg.sv
// Shared widths, request record and lane state for the XDMA descriptor-bypass scheduler.
package xdma_dsc_pkg;

    localparam int XDMA_LEN_W  = 28;
    localparam int XDMA_ADDR_W = 64;
    localparam int XDMA_CTL_W  = 16;
    localparam int CTL_EOP_BIT = 4;
    // One extra bit so boundary room (up to BOUNDARY itself) never overflows.
    localparam int CHUNK_W     = XDMA_LEN_W + 1;

    typedef enum logic [0:0] {
        LANE_IDLE  = 1'b0,
        LANE_ISSUE = 1'b1
    } lane_state_e;

    typedef struct packed {
        logic [XDMA_ADDR_W-1:0] src;
        logic [XDMA_ADDR_W-1:0] dst;
        logic [XDMA_LEN_W-1:0]  len;
    } req_t;

    function automatic logic [CHUNK_W-1:0] min_chunk(input logic [CHUNK_W-1:0] a,
                                                     input logic [CHUNK_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/xdma_dsc_byp_lane.sv
// One bypass channel: request FIFO, split FSM, descriptor outputs and issue counter.
module xdma_dsc_byp_lane
    import xdma_dsc_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_CHUNK = 4096,
    parameter int BOUNDARY  = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [XDMA_ADDR_W-1:0] req_src_addr,
    input  logic [XDMA_ADDR_W-1:0] req_dst_addr,
    input  logic [XDMA_LEN_W-1:0]  req_len,
    output logic                   dsc_byp_load,
    input  logic                   dsc_byp_ready,
    output logic [XDMA_ADDR_W-1:0] dsc_byp_src_addr,
    output logic [XDMA_ADDR_W-1:0] dsc_byp_dst_addr,
    output logic [XDMA_LEN_W-1:0]  dsc_byp_len,
    output logic [XDMA_CTL_W-1:0]  dsc_byp_ctl,
    output logic                   busy,
    output logic [15:0]            issued_cnt,
    output logic                   err_zero_len
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int BND_W = $clog2(BOUNDARY);

    logic [1:0]         rst_sync_q, rst_sync_d;
    logic               lane_rst_n;
    req_t               fifo_mem_q [DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    lane_state_e        state_q, state_d;
    logic [XDMA_ADDR_W-1:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
    logic [XDMA_LEN_W-1:0]  rem_q, rem_d;
    logic [15:0]        issued_cnt_q, issued_cnt_d;
    logic               err_zero_len_q, err_zero_len_d;

    logic               fifo_empty, fifo_full, push, pop, load, eop, issuing, head_zero;
    req_t               head;
    logic [CHUNK_W-1:0] src_room, dst_room, chunk;

    // Reset asserts asynchronously but the lane leaves reset on a clock edge.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    // Two-stage reset release synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    assign lane_rst_n = rst_sync_q[1];

    // FIFO status, handshakes and splitter arithmetic.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        req_ready  = lane_rst_n & ~fifo_full;
        push       = req_valid & req_ready;
        head       = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
        head_zero  = (head.len == '0);
        issuing    = (state_q == LANE_ISSUE);
        src_room   = CHUNK_W'(BOUNDARY) - CHUNK_W'(cur_src_q[BND_W-1:0]);
        dst_room   = CHUNK_W'(BOUNDARY) - CHUNK_W'(cur_dst_q[BND_W-1:0]);
        chunk      = min_chunk(min_chunk({1'b0, rem_q}, CHUNK_W'(MAX_CHUNK)),
                               min_chunk(src_room, dst_room));
        eop        = (chunk == {1'b0, rem_q});
        load       = issuing & dsc_byp_ready;
        // Pop from IDLE, or hand straight over to the next request on the EOP load.
        pop        = ~fifo_empty & (~issuing | (load & eop));
    end

    // Next-state logic: zero-length heads are consumed without entering ISSUE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LANE_IDLE:  if (!fifo_empty && !head_zero) state_d = LANE_ISSUE;
            LANE_ISSUE: if (load && eop)
                            state_d = (!fifo_empty && !head_zero) ? LANE_ISSUE : LANE_IDLE;
            default:    state_d = LANE_IDLE;
        endcase
    end

    // Descriptor outputs come from registers only and are zero outside ISSUE.
    always_comb begin
        dsc_byp_load     = load;
        dsc_byp_src_addr = issuing ? cur_src_q : '0;
        dsc_byp_dst_addr = issuing ? cur_dst_q : '0;
        dsc_byp_len      = issuing ? chunk[XDMA_LEN_W-1:0] : '0;
        dsc_byp_ctl      = '0;
        dsc_byp_ctl[CTL_EOP_BIT] = issuing & eop;
        busy             = ~fifo_empty | issuing;
        issued_cnt       = issued_cnt_q;
        err_zero_len     = err_zero_len_q;
    end

    // Control next values: pointers, counter and sticky error.
    always_comb begin
        wr_ptr_d       = wr_ptr_q + {{PTR_W{1'b0}}, push};
        rd_ptr_d       = rd_ptr_q + {{PTR_W{1'b0}}, pop};
        issued_cnt_d   = issued_cnt_q + 16'(load);
        err_zero_len_d = err_zero_len_q | (pop & head_zero);
    end

    // Working registers: a fresh pop wins over advancing the current request.
    always_comb begin
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        rem_d     = rem_q;
        if (pop && !head_zero) begin
            cur_src_d = head.src;
            cur_dst_d = head.dst;
            rem_d     = head.len;
        end else if (load) begin
            cur_src_d = cur_src_q + XDMA_ADDR_W'(chunk);
            cur_dst_d = cur_dst_q + XDMA_ADDR_W'(chunk);
            rem_d     = rem_q - chunk[XDMA_LEN_W-1:0];
        end
    end

    // Control state; cleared by reset so queued and in-flight work is dropped.
    always_ff @(posedge clk or negedge lane_rst_n) begin
        if (!lane_rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            state_q        <= LANE_IDLE;
            issued_cnt_q   <= '0;
            err_zero_len_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            state_q        <= state_d;
            issued_cnt_q   <= issued_cnt_d;
            err_zero_len_q <= err_zero_len_d;
        end
    end

    // Datapath registers need no reset: they are only observed while in ISSUE.
    always_ff @(posedge clk) begin
        cur_src_q <= cur_src_d;
        cur_dst_q <= cur_dst_d;
        rem_q     <= rem_d;
    end

    // Request storage.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= '{src: req_src_addr, dst: req_dst_addr, len: req_len};
    end

endmodule

// File: rtl/xdma_dsc_byp_sched.sv
// Multi-channel XDMA descriptor-bypass scheduler: one independent lane per bypass port.
module xdma_dsc_byp_sched
    import xdma_dsc_pkg::*;
#(
    parameter int NUM_CHAN  = 4,
    parameter int DEPTH     = 4,
    parameter int MAX_CHUNK = 4096,
    parameter int BOUNDARY  = 4096
) (
    input  logic                            axi_aclk,
    input  logic                            axi_aresetn,
    input  logic [NUM_CHAN-1:0]             req_valid,
    output logic [NUM_CHAN-1:0]             req_ready,
    input  logic [NUM_CHAN*XDMA_ADDR_W-1:0] req_src_addr,
    input  logic [NUM_CHAN*XDMA_ADDR_W-1:0] req_dst_addr,
    input  logic [NUM_CHAN*XDMA_LEN_W-1:0]  req_len,
    output logic [NUM_CHAN-1:0]             dsc_byp_load,
    input  logic [NUM_CHAN-1:0]             dsc_byp_ready,
    output logic [NUM_CHAN*XDMA_ADDR_W-1:0] dsc_byp_src_addr,
    output logic [NUM_CHAN*XDMA_ADDR_W-1:0] dsc_byp_dst_addr,
    output logic [NUM_CHAN*XDMA_LEN_W-1:0]  dsc_byp_len,
    output logic [NUM_CHAN*XDMA_CTL_W-1:0]  dsc_byp_ctl,
    output logic [NUM_CHAN-1:0]             busy,
    output logic [NUM_CHAN*16-1:0]          issued_cnt,
    output logic [NUM_CHAN-1:0]             err_zero_len
);

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_lane
        xdma_dsc_byp_lane #(
            .DEPTH     (DEPTH),
            .MAX_CHUNK (MAX_CHUNK),
            .BOUNDARY  (BOUNDARY)
        ) u_lane (
            .clk              (axi_aclk),
            .rst_n            (axi_aresetn),
            .req_valid        (req_valid[i]),
            .req_ready        (req_ready[i]),
            .req_src_addr     (req_src_addr[i*XDMA_ADDR_W +: XDMA_ADDR_W]),
            .req_dst_addr     (req_dst_addr[i*XDMA_ADDR_W +: XDMA_ADDR_W]),
            .req_len          (req_len[i*XDMA_LEN_W +: XDMA_LEN_W]),
            .dsc_byp_load     (dsc_byp_load[i]),
            .dsc_byp_ready    (dsc_byp_ready[i]),
            .dsc_byp_src_addr (dsc_byp_src_addr[i*XDMA_ADDR_W +: XDMA_ADDR_W]),
            .dsc_byp_dst_addr (dsc_byp_dst_addr[i*XDMA_ADDR_W +: XDMA_ADDR_W]),
            .dsc_byp_len      (dsc_byp_len[i*XDMA_LEN_W +: XDMA_LEN_W]),
            .dsc_byp_ctl      (dsc_byp_ctl[i*XDMA_CTL_W +: XDMA_CTL_W]),
            .busy             (busy[i]),
            .issued_cnt       (issued_cnt[i*16 +: 16]),
            .err_zero_len     (err_zero_len[i])
        );
    end

endmodule

// File: tb/tb_xdma_dsc_byp_sched.sv
// Self-checking bench for xdma_dsc_byp_sched with a request-splitting reference model.
module tb_xdma_dsc_byp_sched;

    localparam int NCH = 2, DEPTH = 4, MAXC = 1024, BND = 4096;

    logic                clk = 1'b0;
    logic                axi_aresetn;
    logic [NCH-1:0]      req_valid, req_ready, dsc_byp_load, dsc_byp_ready, busy, err_zero_len;
    logic [NCH*64-1:0]   req_src_addr, req_dst_addr, dsc_byp_src_addr, dsc_byp_dst_addr;
    logic [NCH*28-1:0]   req_len, dsc_byp_len;
    logic [NCH*16-1:0]   dsc_byp_ctl, issued_cnt;

    always #5 clk = ~clk;

    xdma_dsc_byp_sched #(.NUM_CHAN(NCH), .DEPTH(DEPTH), .MAX_CHUNK(MAXC), .BOUNDARY(BND)) dut (
        .axi_aclk(clk), .axi_aresetn(axi_aresetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src_addr(req_src_addr), .req_dst_addr(req_dst_addr), .req_len(req_len),
        .dsc_byp_load(dsc_byp_load), .dsc_byp_ready(dsc_byp_ready),
        .dsc_byp_src_addr(dsc_byp_src_addr), .dsc_byp_dst_addr(dsc_byp_dst_addr),
        .dsc_byp_len(dsc_byp_len), .dsc_byp_ctl(dsc_byp_ctl),
        .busy(busy), .issued_cnt(issued_cnt), .err_zero_len(err_zero_len)
    );

    typedef struct packed {
        logic [63:0] src;
        logic [63:0] dst;
        logic [27:0] len;
        logic [15:0] ctl;
    } desc_t;

    desc_t exp_q [NCH][$];
    int    exp_cnt [NCH];
    logic  exp_err [NCH];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model: break a request into the descriptors it must produce.
    task automatic model_req(input int ch, input logic [63:0] s, input logic [63:0] d,
                             input logic [27:0] len);
        longint unsigned rem, c, room;
        if (len == 0) begin
            exp_err[ch] = 1'b1;
            return;
        end
        rem = len;
        while (rem != 0) begin
            c = rem;
            if (c > MAXC) c = MAXC;
            room = BND - (s % BND);
            if (c > room) c = room;
            room = BND - (d % BND);
            if (c > room) c = room;
            exp_q[ch].push_back('{src: s, dst: d, len: 28'(c), ctl: (c == rem) ? 16'h0010 : 16'h0000});
            s = s + c;
            d = d + c;
            rem = rem - c;
            exp_cnt[ch]++;
        end
    endtask

    function automatic bit all_empty();
        for (int c = 0; c < NCH; c++) if (exp_q[c].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Scoreboard: every load must match the head of the channel's expected stream.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (dsc_byp_load[c]) begin
                chk($sformatf("load_ready_ch%0d", c), 64'(dsc_byp_ready[c]), 64'd1);
                chk($sformatf("load_expected_ch%0d", c), 64'(exp_q[c].size() != 0), 64'd1);
                if (exp_q[c].size() != 0) begin
                    desc_t e;
                    e = exp_q[c].pop_front();
                    chk($sformatf("dsc_src_ch%0d", c), dsc_byp_src_addr[64*c +: 64], e.src);
                    chk($sformatf("dsc_dst_ch%0d", c), dsc_byp_dst_addr[64*c +: 64], e.dst);
                    chk($sformatf("dsc_len_ch%0d", c), 64'(dsc_byp_len[28*c +: 28]), 64'(e.len));
                    chk($sformatf("dsc_ctl_ch%0d", c), 64'(dsc_byp_ctl[16*c +: 16]), 64'(e.ctl));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic set_req(input int ch, input logic [63:0] s, input logic [63:0] d,
                           input logic [27:0] len);
        req_src_addr[64*ch +: 64] = s;
        req_dst_addr[64*ch +: 64] = d;
        req_len[28*ch +: 28]      = len;
    endtask

    task automatic push_req(input int ch, input logic [63:0] s, input logic [63:0] d,
                            input logic [27:0] len);
        @(posedge clk); #1;
        set_req(ch, s, d, len);
        req_valid[ch] = 1'b1;
        @(negedge clk);
        chk($sformatf("push_ready_ch%0d", ch), 64'(req_ready[ch]), 64'd1);
        model_req(ch, s, d, len);
        @(posedge clk); #1;
        req_valid[ch] = 1'b0;
    endtask

    task automatic drain(input string tag, input int bound);
        int n = 0;
        while (!(all_empty() && busy == '0) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_drained"}, 64'(all_empty() && busy == '0), 64'd1);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s_issued_ch%0d", tag, c), 64'(issued_cnt[16*c +: 16]), 64'(16'(exp_cnt[c])));
            chk($sformatf("%s_err_ch%0d", tag, c), 64'(err_zero_len[c]), 64'(exp_err[c]));
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [NCH-1:0] rdy);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(rdy));
        chk({tag, "_load"}, 64'(dsc_byp_load), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_issued"}, 64'(issued_cnt), 64'd0);
        chk({tag, "_err"}, 64'(err_zero_len), 64'd0);
        chk({tag, "_src"}, 64'(|dsc_byp_src_addr), 64'd0);
        chk({tag, "_dst"}, 64'(|dsc_byp_dst_addr), 64'd0);
        chk({tag, "_len"}, 64'(dsc_byp_len), 64'd0);
        chk({tag, "_ctl"}, 64'(dsc_byp_ctl), 64'd0);
    endtask

    initial begin
        logic [NCH-1:0]  pend;
        logic [63:0]     ps [NCH];
        logic [63:0]     pd [NCH];
        logic [27:0]     pl [NCH];
        int              remaining;

        axi_aresetn = 1'b0; req_valid = '0; dsc_byp_ready = '0;
        req_src_addr = '0; req_dst_addr = '0; req_len = '0;
        for (int c = 0; c < NCH; c++) begin exp_cnt[c] = 0; exp_err[c] = 1'b0; end

        // Reset state, then release.
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("in_reset", '0);
        axi_aresetn = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_idle_outputs("after_reset", '1);

        // Boundary split with latency check.
        dsc_byp_ready = '1;
        push_req(0, 64'h1000_0F00, 64'h2000_0000, 28'h300);
        @(negedge clk) chk("lat_t1_no_load", 64'(dsc_byp_load[0]), 64'd0);
        @(negedge clk) chk("lat_t2_load", 64'(dsc_byp_load[0]), 64'd1);
        chk("split1_len", 64'(dsc_byp_len[27:0]), 64'h100);
        chk("split1_ctl", 64'(dsc_byp_ctl[15:0]), 64'h0);
        @(negedge clk) chk("split2_src", dsc_byp_src_addr[63:0], 64'h1000_1000);
        chk("split2_len", 64'(dsc_byp_len[27:0]), 64'h200);
        chk("split2_ctl", 64'(dsc_byp_ctl[15:0]), 64'h10);
        drain("boundary", 50);

        // Max chunk split, then a 2^64 wrap-around request.
        push_req(0, 64'h3000_0000, 64'h4000_0000, 28'hA00);
        drain("maxchunk", 50);
        chk("maxchunk_count", 64'(issued_cnt[15:0]), 64'd5);
        push_req(0, 64'hFFFF_FFFF_FFFF_FF00, 64'h0000_0000_5000_0000, 28'h300);
        drain("wrap", 50);

        // Backpressure mid-request on channel 1.
        dsc_byp_ready[1] = 1'b0;
        push_req(1, 64'h5000_0000, 64'h6000_0000, 28'hA00);
        @(posedge clk); #1 dsc_byp_ready[1] = 1'b1;
        @(posedge clk); #1 dsc_byp_ready[1] = 1'b0;
        remaining = exp_q[1].size();
        chk("bp_remaining", 64'(remaining), 64'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_load", 64'(dsc_byp_load[1]), 64'd0);
            if (exp_q[1].size() != 0) begin
                chk("bp_hold_src", dsc_byp_src_addr[127:64], exp_q[1][0].src);
                chk("bp_hold_len", 64'(dsc_byp_len[55:28]), 64'(exp_q[1][0].len));
                chk("bp_hold_ctl", 64'(dsc_byp_ctl[31:16]), 64'(exp_q[1][0].ctl));
            end
        end
        @(posedge clk); #1 dsc_byp_ready[1] = 1'b1;
        for (int i = 0; i < remaining; i++) @(negedge clk) chk("bp_b2b_load", 64'(dsc_byp_load[1]), 64'd1);
        drain("backpressure", 50);

        // FIFO full: four FIFO slots plus the request held by the lane.
        dsc_byp_ready[0] = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            logic [63:0] s, d;
            logic [27:0] l;
            s = {32'h0, $urandom} & 64'hFFFF_FFF0;
            d = {32'h7, $urandom};
            l = 28'($urandom_range(1, 'h900));
            set_req(0, s, d, l);
            req_valid[0] = 1'b1;
            @(negedge clk);
            chk($sformatf("full_ready_k%0d", k), 64'(req_ready[0]), (k < 5) ? 64'd1 : 64'd0);
            if (k < 5) model_req(0, s, d, l);
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        chk("full_busy", 64'(busy[0]), 64'd1);
        dsc_byp_ready[0] = 1'b1;
        drain("fifo_full", 400);

        // Zero-length request is dropped and flagged; the next one is normal.
        push_req(0, 64'h8000_0000, 64'h9000_0000, 28'h0);
        repeat (4) @(posedge clk);
        #1 chk("zero_err", 64'(err_zero_len), 64'b01);
        chk("zero_busy", 64'(busy[0]), 64'd0);
        chk("zero_no_issue", 64'(issued_cnt[15:0]), 64'(16'(exp_cnt[0])));
        push_req(0, 64'h8000_0800, 64'h9000_0000, 28'h1000);
        drain("zero_len", 50);

        // Randomised traffic with random XDMA backpressure.
        pend = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk); #1;
            for (int c = 0; c < NCH; c++) begin
                if (!pend[c]) req_valid[c] = 1'b0;
                dsc_byp_ready[c] = ($urandom_range(0, 3) != 0);
                if (!pend[c] && $urandom_range(0, 3) == 0) begin
                    ps[c] = {$urandom, $urandom};
                    pd[c] = {$urandom, $urandom};
                    pl[c] = ($urandom_range(0, 15) == 0) ? 28'h0 : 28'($urandom_range(1, 'h1800));
                    set_req(c, ps[c], pd[c], pl[c]);
                    req_valid[c] = 1'b1;
                    pend[c] = 1'b1;
                end
            end
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (pend[c] && req_ready[c]) begin
                    model_req(c, ps[c], pd[c], pl[c]);
                    pend[c] = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        dsc_byp_ready = '1;
        drain("random", 2000);

        // Reset during the second of three descriptors.
        push_req(0, 64'hA000_0000, 64'hB000_0000, 28'hC00);
        @(posedge clk);
        @(posedge clk); #2;
        axi_aresetn = 1'b0;
        for (int c = 0; c < NCH; c++) begin exp_q[c].delete(); exp_cnt[c] = 0; exp_err[c] = 1'b0; end
        #1 check_idle_outputs("mid_reset", '0);
        repeat (3) @(posedge clk);
        #1 axi_aresetn = 1'b1;
        repeat (12) @(posedge clk);
        #1 check_idle_outputs("post_reset", '1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
